// File: rtl/axi4_bram_responder.sv
// ---------------------------------------------------------------------------
// axi4_bram_responder
//
// AXI4 responder backed by an on-chip synchronous RAM. It stands in for the
// DDR4 controller as the target of the NoC-to-AXI4 bridge. INCR and FIXED
// bursts are carried out. WRAP and reserved burst types are answered with
// SLVERR: writes are dropped and reads return zeros, but the beat count is
// still honoured. The write and read engines are independent, and each one
// holds a single outstanding burst.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   s_axi_aw*           write address channel (awready is registered)
//   s_axi_w*            write data channel
//   s_axi_b*            write response channel (bid echoes awid)
//   s_axi_ar*           read address channel (arready is registered)
//   s_axi_r*            read data channel (rid echoes arid)
// ---------------------------------------------------------------------------
module axi4_bram_responder #(
    parameter int ID_WIDTH       = 16,
    parameter int ADDR_WIDTH     = 35,
    parameter int DATA_WIDTH     = 512,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
    localparam int DEPTH       = 1 << MEM_WORDS_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = {{(MEM_WORDS_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

    // INCR moves one word per beat whatever the size field says. The index
    // width makes it wrap modulo the RAM depth. FIXED keeps the same word.
    function automatic logic [MEM_WORDS_LOG2-1:0] step_idx(input logic [MEM_WORDS_LOG2-1:0] idx,
                                                           input logic [1:0] burst);
        return (burst == BURST_INCR) ? idx + IDX_ONE : idx;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write engine state
    w_state_t                  w_state, w_next;
    logic                      awready_q;
    logic [ID_WIDTH-1:0]       w_id;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic [7:0]                w_len, w_cnt;
    logic [1:0]                w_burst;
    logic [1:0]                bresp_q;
    logic                      aw_hs, w_beat;

    // Read engine state
    r_state_t                  r_state, r_next;
    logic                      arready_q;
    logic [ID_WIDTH-1:0]       r_id;
    logic [MEM_WORDS_LOG2-1:0] r_idx, r_idx_next, ar_idx;
    logic [7:0]                r_len, r_cnt;
    logic [1:0]                r_burst;
    logic [1:0]                rresp_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      ar_hs, r_hs, r_at_len;

    // Only the word-index slice of the address matters. Upper bits alias, and
    // the beat size does not change the per-beat step.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr[ADDR_WIDTH-1:OFFSET_BITS+MEM_WORDS_LOG2],
                             s_axi_awaddr[OFFSET_BITS-1:0], s_axi_awsize,
                             s_axi_araddr[ADDR_WIDTH-1:OFFSET_BITS+MEM_WORDS_LOG2],
                             s_axi_araddr[OFFSET_BITS-1:0], s_axi_arsize};

    assign s_axi_awready = awready_q;
    assign s_axi_bid     = w_id;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_arready = arready_q;
    assign s_axi_rid     = r_id;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rlast   = (r_state == R_DATA) && r_at_len;

    // Write next-state logic. The burst closes on the beat that reaches awlen,
    // or on an early wlast. Beats after a missing wlast are left for the next
    // burst.
    always_comb begin
        w_next       = w_state;
        s_axi_wready = 1'b0;
        w_beat       = 1'b0;
        aw_hs        = s_axi_awvalid && awready_q;
        case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    w_beat = 1'b1;
                    if ((w_cnt == w_len) || s_axi_wlast) w_next = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write state register and burst bookkeeping. awready comes from a flop,
    // so it stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_burst   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            if (w_state == W_IDLE && aw_hs) begin
                w_id    <= s_axi_awid;
                w_idx   <= s_axi_awaddr[OFFSET_BITS +: MEM_WORDS_LOG2];
                w_len   <= s_axi_awlen;
                w_burst <= s_axi_awburst;
                w_cnt   <= '0;
            end
            if (w_beat) begin
                w_cnt <= w_cnt + 8'd1;
                w_idx <= step_idx(w_idx, w_burst);
                if (w_next == W_RESP) begin
                    bresp_q <= (!burst_ok(w_burst) || (s_axi_wlast != (w_cnt == w_len)))
                               ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Byte-strobed RAM write. This block has no reset, so RAM contents survive
    // a reset.
    always_ff @(posedge clk) begin
        if (w_beat && burst_ok(w_burst)) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Read next-state logic. A handshake on the beat numbered arlen ends the
    // burst.
    always_comb begin
        r_next     = r_state;
        ar_hs      = s_axi_arvalid && arready_q;
        r_at_len   = (r_cnt == r_len);
        r_hs       = (r_state == R_DATA) && s_axi_rready;
        ar_idx     = s_axi_araddr[OFFSET_BITS +: MEM_WORDS_LOG2];
        r_idx_next = step_idx(r_idx, r_burst);
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (s_axi_rready && r_at_len) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read state register and data register. rdata is loaded on the AR
    // handshake and on every non-final R handshake. Between those events it
    // holds, which keeps a stalled beat stable. A write to the same word on
    // the same edge is not visible here, so the read sees the old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (r_state == R_IDLE && ar_hs) begin
                r_id    <= s_axi_arid;
                r_idx   <= ar_idx;
                r_len   <= s_axi_arlen;
                r_burst <= s_axi_arburst;
                r_cnt   <= '0;
                rresp_q <= burst_ok(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
                rdata_q <= burst_ok(s_axi_arburst) ? mem[ar_idx] : '0;
            end else if (r_hs && !r_at_len) begin
                r_cnt   <= r_cnt + 8'd1;
                r_idx   <= r_idx_next;
                rdata_q <= burst_ok(r_burst) ? mem[r_idx_next] : '0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_bram_responder.sv
// ---------------------------------------------------------------------------
// tb_axi4_bram_responder
//
// Directed testbench for axi4_bram_responder. It drives write and read bursts
// and compares every response field with values computed inside the bench.
// ---------------------------------------------------------------------------
module tb_axi4_bram_responder;

    localparam int ID_WIDTH   = 16;
    localparam int ADDR_WIDTH = 35;
    localparam int DATA_WIDTH = 512;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int DW         = DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ID_WIDTH-1:0]   awid, bid, arid, rid;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [7:0]            awlen, arlen;
    logic [2:0]            awsize, arsize;
    logic [1:0]            awburst, arburst, bresp, rresp;
    logic                  awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rlast, rvalid, rready;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [STRB_WIDTH-1:0] wstrb;

    int errors = 0;
    int checks = 0;

    logic [DATA_WIDTH-1:0] w_data [8];
    logic [STRB_WIDTH-1:0] w_strb [8];
    logic                  w_last [8];
    logic [DATA_WIDTH-1:0] exp_data [8];
    logic                  rr_pat [16];
    logic [ID_WIDTH-1:0]   got_bid;
    logic [1:0]            got_bresp;
    int                    read_cycles;
    logic [DATA_WIDTH-1:0] old_beat2;

    axi4_bram_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    // Counts one comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                               input logic [DATA_WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    // Fills the write-beat table: full strobes, wlast on beat last_at (-1 = none)
    task automatic setBeats(input logic [31:0] seed, input int last_at);
        for (int i = 0; i < 8; i++) begin
            w_data[i] = pat(seed + 32'(i));
            w_strb[i] = '1;
            w_last[i] = (i == last_at);
        end
    endtask

    // Runs one write burst of nbeats from the beat table and collects the B response
    task automatic applyWrite(input logic [15:0] id, input logic [34:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int nbeats);
        int cyc;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd6; awburst = burst; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checkOutput("aw_ready", DW'(awready), DW'(1'b1));
        @(posedge clk); #1;
        awvalid = 1'b0;
        checkOutput("aw_drop", DW'(awready), DW'(1'b0));
        for (int i = 0; i < nbeats; i++) begin
            wdata = w_data[i]; wstrb = w_strb[i]; wlast = w_last[i]; wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < 20) begin @(posedge clk); #1; cyc++; end
            checkOutput("w_ready", DW'(wready), DW'(1'b1));
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checkOutput("b_valid", DW'(bvalid), DW'(1'b1));
        got_bid = bid; got_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("aw_ready_after_b", DW'(awready), DW'(1'b1));
    endtask

    // Runs one read burst with rready taken from rr_pat and checks every valid cycle
    task automatic applyRead(input logic [15:0] id, input logic [34:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [1:0] exp_resp);
        int cyc;
        int beat;
        arid = id; araddr = addr; arlen = len; arsize = 3'd6; arburst = burst; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checkOutput("ar_ready", DW'(arready), DW'(1'b1));
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("r_latency", DW'(rvalid), DW'(1'b1));
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 64) begin
            rready = (cyc < 16) ? rr_pat[cyc] : 1'b1;
            if (rvalid) begin
                checkOutput("r_data", rdata, exp_data[beat]);
                checkOutput("r_id", DW'(rid), DW'(id));
                checkOutput("r_resp", DW'(rresp), DW'(exp_resp));
                checkOutput("r_last", DW'(rlast), DW'(beat == int'(len)));
                if (rready) beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        read_cycles = cyc;
        checkOutput("r_beats", DW'(beat), DW'(int'(len) + 1));
        checkOutput("r_done", DW'(rvalid), DW'(1'b0));
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        for (int i = 0; i < 16; i++) rr_pat[i] = 1'b1;

        // Reset state: every output is low while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", DW'({awready, wready, bvalid, arready, rvalid, rlast}), DW'(6'b0));
        rst = 1'b0;
        checkOutput("ready_before_edge", DW'({awready, arready}), DW'(2'b00));
        @(posedge clk); #1;
        checkOutput("ready_after_reset", DW'({awready, arready}), DW'(2'b11));

        // Single-beat write then read-back at 0x40
        setBeats(32'hA5A5_0001, 0);
        applyWrite(16'h1234, 35'h40, 8'd0, 2'b01, 1);
        checkOutput("single_bid", DW'(got_bid), DW'(16'h1234));
        checkOutput("single_bresp", DW'(got_bresp), DW'(2'b00));
        exp_data[0] = pat(32'hA5A5_0001);
        applyRead(16'h55AA, 35'h40, 8'd0, 2'b01, 2'b00);

        // INCR burst of 4 at 0x1000, then rewrite it with a partial strobe on beat 2
        setBeats(32'h1111_0000, 3);
        applyWrite(16'h0002, 35'h1000, 8'd3, 2'b01, 4);
        checkOutput("incr_old_bresp", DW'(got_bresp), DW'(2'b00));
        old_beat2 = pat(32'h1111_0002);
        setBeats(32'hBEEF_0000, 3);
        w_strb[2] = 64'h0F;
        applyWrite(16'h0003, 35'h1000, 8'd3, 2'b01, 4);
        checkOutput("incr_bresp", DW'(got_bresp), DW'(2'b00));
        checkOutput("incr_bid", DW'(got_bid), DW'(16'h0003));
        for (int i = 0; i < 4; i++) exp_data[i] = pat(32'hBEEF_0000 + 32'(i));
        exp_data[2] = {old_beat2[DATA_WIDTH-1:32], 32'hBEEF_0002};
        applyRead(16'h0004, 35'h1000, 8'd3, 2'b01, 2'b00);
        checkOutput("incr_back_to_back", DW'(read_cycles), DW'(4));

        // 8-beat read with rready 1,0,0,1 then held high
        setBeats(32'h2222_0000, 7);
        applyWrite(16'h0005, 35'h2000, 8'd7, 2'b01, 8);
        for (int i = 0; i < 8; i++) exp_data[i] = pat(32'h2222_0000 + 32'(i));
        rr_pat[1] = 1'b0; rr_pat[2] = 1'b0;
        applyRead(16'h0006, 35'h2000, 8'd7, 2'b01, 2'b00);
        rr_pat[1] = 1'b1; rr_pat[2] = 1'b1;
        checkOutput("stall_cycles", DW'(read_cycles), DW'(10));

        // WRAP write is refused and leaves RAM alone; reserved read returns zeros
        setBeats(32'hDEAD_0000, 1);
        applyWrite(16'h0007, 35'h40, 8'd1, 2'b10, 2);
        checkOutput("wrap_bresp", DW'(got_bresp), DW'(2'b10));
        exp_data[0] = pat(32'hA5A5_0001);
        applyRead(16'h0008, 35'h40, 8'd0, 2'b01, 2'b00);
        exp_data[0] = '0; exp_data[1] = '0;
        applyRead(16'h0009, 35'h40, 8'd1, 2'b11, 2'b10);

        // Early wlast, then missing wlast on the final beat
        setBeats(32'h3333_0000, 1);
        applyWrite(16'h000A, 35'h3000, 8'd3, 2'b01, 2);
        checkOutput("early_wlast_bresp", DW'(got_bresp), DW'(2'b10));
        setBeats(32'h3434_0000, -1);
        applyWrite(16'h000B, 35'h3000, 8'd1, 2'b01, 2);
        checkOutput("missing_wlast_bresp", DW'(got_bresp), DW'(2'b10));
        checkOutput("missing_wlast_bid", DW'(got_bid), DW'(16'h000B));

        // Reset during beat 2 of a 4-beat write with a concurrent read
        setBeats(32'h4444_0000, 3);
        awid = 16'h0707; awaddr = 35'h4000; awlen = 8'd3; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
        arid = 16'h0808; araddr = 35'h2000; arlen = 8'd7; arsize = 3'd6; arburst = 2'b01; arvalid = 1'b1;
        checkOutput("aw_ar_both_ready", DW'({awready, arready}), DW'(2'b11));
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        checkOutput("both_accepted", DW'({wready, rvalid}), DW'(2'b11));
        wdata = w_data[0]; wstrb = w_strb[0]; wlast = 1'b0; wvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        wdata = w_data[1];
        rst = 1'b1;
        #1;
        checkOutput("abort_ctrl", DW'({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid}),
                    DW'(1'b0));
        checkOutput("abort_rdata", rdata, '0);
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_ready", DW'({awready, arready, bvalid, rvalid}), DW'(4'b1100));
        exp_data[0] = pat(32'h4444_0000);
        applyRead(16'h000C, 35'h4000, 8'd0, 2'b01, 2'b00);
        setBeats(32'h5555_0000, 0);
        applyWrite(16'h000D, 35'h5000, 8'd0, 2'b01, 1);
        checkOutput("post_reset_bresp", DW'(got_bresp), DW'(2'b00));
        checkOutput("post_reset_bid", DW'(got_bid), DW'(16'h000D));
        exp_data[0] = pat(32'h5555_0000);
        applyRead(16'h000E, 35'h5000, 8'd0, 2'b01, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
